// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared types and constants for the parametrised register file.
//   state_t    : sweep FSM state (IDLE, CLEAR)
//   *_DEF      : default word/address widths
//   NREAD_MAX  : largest supported number of read ports
//   depth_of() : number of words for a given address width
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREAD_MAX  = 4;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_rd_mux.sv
// regfile_rd_mux -- one combinational read port of the register file.
//   addr   : read address
//   stored : word currently held in the array at addr
//   byp_en : a write is being performed this cycle and may be forwarded
//   waddr  : address of that write
//   wdata  : data of that write
//   data   : value presented on the port
// Register 0 is forced to zero when ZERO_REG is non-zero; that check is
// applied last so forwarding can never leak a value onto address 0.
module regfile_rd_mux
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    // NOTE: assigning a default first keeps this purely combinational; a
    // path that left data unassigned would infer a latch.
    data = stored;
    if (byp_en && (addr == waddr)) data = wdata;
    if ((ZERO_REG != 0) && (addr == '0)) data = '0;
  end

endmodule

// File: rtl/regfile_param.sv
// regfile_param -- parametrised register file with a sequenced bulk clear.
//   clk       : clock, all state on the rising edge
//   rst       : synchronous active-high reset (clears every word)
//   we/waddr/wdata : single synchronous write port (performed only in IDLE)
//   raddr/rdata    : NREAD packed combinational read ports
//   test_addr/test_data : debug read port for the display
//   clr_req   : level-sampled bulk-clear request
//   busy      : high while the clear sweep runs
//   wr_drop   : one-cycle pulse after a write was rejected during a sweep
//   clr_done  : one-cycle pulse after the last word of a sweep is cleared
// Optional: define REGFILE_BYPASS_EN to forward a performed write to any
// read port addressing it in the same cycle.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  input  logic [ADDR_W-1:0]        test_addr,
  output logic [DATA_W-1:0]        test_data,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     wr_drop,
  output logic                     clr_done
);

  localparam int DEPTH = depth_of(ADDR_W);

  if (NREAD < 1 || NREAD > NREAD_MAX) begin : g_bad_nread
    $error("regfile_param: NREAD out of range");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              wr_fire;
  logic              byp_en;

  // A write lands only in IDLE and never on the hardwired-zero register.
  assign wr_fire = (state == IDLE) && we && !((ZERO_REG != 0) && (waddr == '0));

`ifdef REGFILE_BYPASS_EN
  assign byp_en = wr_fire;
`else
  assign byp_en = 1'b0;
`endif

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array itself is reset because a cleared file is part of
      // the visible reset state, not just the control registers.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      wr_drop  <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      wr_drop  <= 1'b0;
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          // The write on the request edge still completes; the sweep
          // starts on the following edge.
          if (wr_fire) mem[waddr] <= wdata;
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          mem[cnt] <= '0;
          cnt      <= cnt + 1'b1;
          wr_drop  <= we;
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_rd_mux #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .addr  (raddr[k*ADDR_W +: ADDR_W]),
      .stored(mem[raddr[k*ADDR_W +: ADDR_W]]),
      .byp_en(byp_en),
      .waddr (waddr),
      .wdata (wdata),
      .data  (rdata[k*DATA_W +: DATA_W])
    );
  end

  regfile_rd_mux #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ZERO_REG(ZERO_REG)
  ) u_rd_test (
    .addr  (test_addr),
    .stored(mem[test_addr]),
    .byp_en(byp_en),
    .waddr (waddr),
    .wdata (wdata),
    .data  (test_data)
  );

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor register file: DEPTH = 2**ADDR_W words of DATA_W bits, NREAD independent combinational read ports, one synchronous write port, and one test/debug read port driving the display.
- Adds a sequenced bulk-clear engine, a busy/drop handshake and an optional hardwired-zero register 0.
- Sits between the datapath writeback stage and the operand-fetch/display logic.

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W.
- NREAD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr  in  NREAD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rdata  out  NREAD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].
- test_addr  in  ADDR_W  debug read address.
- test_data  out  DATA_W  debug read data.
- clr_req  in  1  bulk-clear request, level-sampled.
- busy  out  1  high while a clear sweep is in progress.
- wr_drop  out  1  one-cycle pulse: a write was rejected.
- clr_done  out  1  one-cycle pulse on the cycle the sweep finishes.

Behaviour:
- Reset (rst=1 at an edge):
  - All DEPTH words become 0.
  - FSM goes to IDLE and the sweep counter goes to 0.
  - busy=0, wr_drop=0, clr_done=0 from the next cycle.
  - rst overrides clr_req and we. Reset mid-sweep aborts the sweep with no clr_done.
- Write: in IDLE, with we=1 at a rising edge, word[waddr] takes wdata. The value is visible on the read ports from the next cycle.
  - ZERO_REG=1 and waddr=0: the write is silently ignored. This is not a drop, so wr_drop stays 0.
- Read: rdata[k] = word[raddr[k]] and test_data = word[test_addr], purely combinational.
  - ZERO_REG=1 with address 0 always returns 0.
  - All ports may use the same address at once.
- FSM states are IDLE and CLEAR.
  - IDLE -> CLEAR when clr_req=1 at an edge. That same edge loads cnt=0 and sets busy=1.
  - A write presented on the IDLE->CLEAR edge is still performed: the write has priority for that edge, and the sweep begins on the next edge.
  - In CLEAR, each edge sets word[cnt]=0 and increments cnt. The sweep takes exactly DEPTH cycles.
  - When cnt=DEPTH-1 the clear happens and the FSM returns to IDLE. busy=0 and clr_done=1 on the following cycle, for one cycle only.
  - clr_req held high during CLEAR is ignored. clr_req still high on return to IDLE starts a new sweep on the next edge.
- Writes during CLEAR (we=1 while busy=1) are not performed; wr_drop=1 on the next cycle.
- Reads during CLEAR return current contents: addresses below cnt read 0, addresses at or above cnt read old data.
- Address width: all addresses are exactly ADDR_W bits, so there are no out-of-range addresses.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: any read port (including test) whose address equals waddr while we=1 and the write would be performed returns wdata in that same cycle (write-through forwarding). This never applies to address 0 with ZERO_REG=1, and never during CLEAR.
- Undefined: reads return the stored value; new data appears one cycle after the write.

Decomposition:
- Package regfile_pkg holds:
  - The FSM state enum (IDLE, CLEAR).
  - Default constants DATA_W_DEF=32, ADDR_W_DEF=5, NREAD_MAX=4.
  - A helper function for DEPTH.
- One sub-module, regfile_rd_mux (ADDR_W, DATA_W), is natural. It is a single read port with the zero-register and bypass logic, instantiated NREAD+1 times.

Test Plan:
- Reset, then read all 32 addresses on both ports and the test port -> every value 0; busy=0.
- Write 0xDEADBEEF to addr 7, read with raddr0=raddr1=7 -> 0xDEADBEEF from the next cycle. Same cycle gives old 0, or 0xDEADBEEF when REGFILE_BYPASS_EN is defined.
- ZERO_REG=1: write 0x12345678 to addr 0 -> reads 0, wr_drop stays 0. ZERO_REG=0: reads 0x12345678.
- Fill addrs 1..31 with the value equal to the address, pulse clr_req -> busy high for 32 cycles. After 10 cycles addr 5 reads 0 and addr 20 reads 20. clr_done pulses once; afterwards all addresses read 0.
- Write 0xAA to addr 3 while busy -> wr_drop pulses next cycle, addr 3 stays 0. Write 0xBB to addr 4 on the clr_req edge -> 0xBB stored, then cleared by the sweep.
- Assert rst at sweep cycle 12 -> busy=0 next cycle, no clr_done, all words 0. A write to addr 9 on the following cycle succeeds.
